// File: rtl/time_gated_arbiter.sv
// Arbiter for one dequeue port shared by N_REQ timestamped requesters.
// Only requests whose time has come are granted, and the most overdue one is granted first.
//
// state  | meaning
// S_IDLE | no entry presented; arbitrate among eligible requests each cycle
// S_HOLD | granted entry presented on out_*; wait for out_ready
module time_gated_arbiter #(
  parameter int          N_REQ    = 4,
  parameter int          TIME_LOG = 32,
  parameter int unsigned LATE_MAX = 1000,
  parameter int          IDX_W    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TIME_LOG-1:0]       curr_time,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TIME_LOG-1:0] req_time,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_idx,
  output logic [TIME_LOG-1:0]       out_time,
  output logic [TIME_LOG-1:0]       out_late,
  output logic [15:0]               late_cnt
);

  localparam int LW = (TIME_LOG > 32) ? TIME_LOG : 32;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_REQ-1:0]    r_req_ready;
  logic [IDX_W-1:0]    r_out_idx;
  logic [TIME_LOG-1:0] r_out_time;
  logic [TIME_LOG-1:0] r_out_late;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [15:0]         r_late_cnt;

  logic [TIME_LOG-1:0] w_lat [N_REQ];
  logic [N_REQ-1:0]    w_elig;
  logic [IDX_W:0]      w_cand;
  logic [IDX_W-1:0]    w_idx;
  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [TIME_LOG-1:0] w_win_lat;
  logic                w_grant;
  logic [IDX_W-1:0]    w_rr_nxt;
  logic                w_is_late;
  logic [N_REQ-1:0]    w_onehot;

  // Lateness is modular, so a timestamp more than half the range behind reads as future.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_lat[i]  = curr_time - req_time[i*TIME_LOG +: TIME_LOG];
      w_elig[i] = req_valid[i] & ~w_lat[i][TIME_LOG-1];
    end
  end

  // Scan starting at rr_ptr; strict '>' keeps the first tied index in cyclic order.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_win_lat = '0;
    w_cand    = '0;
    w_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(N_REQ))
        w_cand = w_cand - (IDX_W+1)'(N_REQ);
      w_idx = w_cand[IDX_W-1:0];
      if (w_elig[w_idx] && (!w_found || (w_lat[w_idx] > w_win_lat))) begin
        w_found   = 1'b1;
        w_win     = w_idx;
        w_win_lat = w_lat[w_idx];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rr_nxt  = (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + 1'b1;
  assign w_is_late = LW'(w_win_lat) > LW'(LATE_MAX);
  assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= '0;
      r_out_idx   <= '0;
      r_out_time  <= '0;
      r_out_late  <= '0;
      r_rr_ptr    <= '0;
      r_late_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= '0;
      if (w_grant) begin
        r_req_ready <= w_onehot;
        r_out_idx   <= w_win;
        r_out_time  <= req_time[w_win*TIME_LOG +: TIME_LOG];
        r_out_late  <= w_win_lat;
        r_rr_ptr    <= w_rr_nxt;
        if (w_is_late && (r_late_cnt != 16'hFFFF))
          r_late_cnt <= r_late_cnt + 16'd1;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign out_valid = (r_state == S_HOLD);
  assign out_idx   = r_out_idx;
  assign out_time  = r_out_time;
  assign out_late  = r_out_late;
  assign late_cnt  = r_late_cnt;

endmodule

// File: doc/time_gated_arbiter.md
# time_gated_arbiter

Shares a single downstream dequeue port between N_REQ requesters. Each request carries an eligibility timestamp, and the block grants only requests whose timestamp the wall-clock time `curr_time` has reached. Among eligible requests it grants the most overdue one. It sits between the per-queue shapers and the scheduler output stage, fed by the common free-running wall clock.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `TIME_LOG`, default 32: width of timestamps and `curr_time`.
- `LATE_MAX`, default 1000: a grant counts as late when its lateness exceeds this many cycles.
- `IDX_W`, default $clog2(N_REQ): width of the index fields.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `curr_time`, in, TIME_LOG: wall-clock time; increments by 1 per cycle and wraps.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_time`, in, N_REQ*TIME_LOG: per-requester eligibility time; requester i uses slice [i*TIME_LOG +: TIME_LOG].
- `req_ready`, out, N_REQ: per-requester grant acknowledge; registered, one-hot or zero.
- `out_valid`, out, 1: a granted entry is presented.
- `out_ready`, in, 1: downstream accepts the entry.
- `out_idx`, out, IDX_W: index of the granted requester.
- `out_time`, out, TIME_LOG: `req_time` of the granted request.
- `out_late`, out, TIME_LOG: lateness of the grant, `curr_time − req_time` sampled at decision.
- `late_cnt`, out, 16: saturating count of late grants.

## Operation
- Requester protocol:
  - Requester i holds `req_valid[i]` and its `req_time` slice stable until the edge where `req_valid[i] & req_ready[i]` is high.
  - That edge completes the handshake.
  - The requester may present a new request from the next cycle.
- Lateness: `lat_i = curr_time − req_time_i`, computed modulo 2^TIME_LOG.
- Eligibility: requester i is eligible when `req_valid[i]` is high and the MSB of `lat_i` is 0, i.e. lateness lies in [0, 2^(TIME_LOG−1)).
  - Timestamps more than half the range in the past are treated as future; the block never grants them.
- Selection: the eligible requester with the largest `lat_i` wins.
  - Ties go to the first tied index at or after `rr_ptr`, searching cyclically.
  - On each grant, `rr_ptr` ← (winner + 1) mod N_REQ.
- States:
  - **IDLE**: `out_valid` = 0. If any requester is eligible, latch `out_idx`, `out_time` and `out_late`, set `req_ready[winner]` for the next cycle, update `rr_ptr` and `late_cnt`, and go to HOLD. Otherwise stay in IDLE.
  - **HOLD**: `out_valid` = 1 and the output registers stay stable. When `out_ready` is high, go to IDLE; otherwise stay in HOLD. No arbitration happens in HOLD.
- `late_cnt` increments on a grant when `out_late > LATE_MAX` (unsigned compare). It saturates at 0xFFFF.
- Reset sets:
  - state to IDLE;
  - `out_valid`, `req_ready`, `out_idx`, `out_time`, `out_late`, `rr_ptr` and `late_cnt` to 0.
  - A grant in flight is dropped; the requester keeps requesting and is re-arbitrated after reset.

## Timing
- Decision at cycle T (IDLE with at least one eligible request) gives:
  - `out_valid` = 1 and `req_ready[w]` = 1 in cycle T+1;
  - `req_ready` back to 0 in T+2.
- `req_ready` is high for exactly one cycle per grant. It is never high for two requesters at once, and never high while the block is in IDLE.
- If `out_ready` is high in T+1, the block is in IDLE at T+2 and can make its next decision at T+2. Peak throughput is one grant per 2 cycles.
- The decision at T uses the `curr_time` and `req_*` values present during cycle T.
- A request that becomes eligible while the block is in HOLD waits for the next IDLE cycle.
- When `curr_time` wraps from 2^TIME_LOG−1 to 0, eligibility and ordering continue correctly through the wrap.

## Test plan
- **Single requester, future timestamp.** Requester 0 presents `req_time` = 100 while `curr_time` = 90 and `out_ready` = 1. Required: no `out_valid` while `curr_time` < 100. The decision is made in the cycle where `curr_time` = 100; `out_valid` rises one cycle later with `out_idx` = 0, `out_time` = 100, `out_late` = 0, and `req_ready[0]` pulses for one cycle.
- **Most-overdue selection.** At `curr_time` = 500, requesters 1, 2 and 3 present `req_time` 480, 450 and 499. Required: grants in the order 2, 1, 3, with `out_late` of 50, then 22 (decision at 502), then 5 (decision at 504).
- **Tie round-robin.** All four requesters hold `req_time` = 0, are re-armed after each handshake, and `out_ready` is held at 1. Required: `out_idx` sequence 0, 1, 2, 3, 0, …
- **Wrap-around.** With TIME_LOG = 8, `curr_time` = 250 and `req_time` = 3, the request is not granted until `curr_time` = 3 after the wrap; `out_late` = 0. Separately, `req_time` = 250 presented at `curr_time` = 4 is eligible immediately with `out_late` = 10.
- **Backpressure and late count.** `out_ready` = 0 for 20 cycles, with a second request pending. Required: `out_*` stay stable, there is no second `req_ready` pulse, and the second grant follows within 2 cycles of `out_ready` rising. Separately, with LATE_MAX = 1000, a grant with `out_late` = 1001 takes `late_cnt` from 0 to 1, and one with `out_late` = 1000 leaves it unchanged.
- **Reset mid-operation.** Assert `rst` while in HOLD with `out_idx` = 2. Required: one cycle later all outputs are 0, and after `rst` falls requester 2, still holding its request, is re-granted.
